// File: rtl/simd_pe_array_pkg.sv
// Shared definitions for the SIMD PE array: op encodings and the stage payload.
// Optional accumulator build is selected with the SIMD_PE_ACC_EN macro.
package simd_pe_array_pkg;

  localparam int OP_SEL_WIDTH = 2;

  localparam logic [OP_SEL_WIDTH-1:0] OP_ADD = 2'd0;
  localparam logic [OP_SEL_WIDTH-1:0] OP_SUB = 2'd1;
  localparam logic [OP_SEL_WIDTH-1:0] OP_MUL = 2'd2;
  localparam logic [OP_SEL_WIDTH-1:0] OP_XOR = 2'd3;

  // Payload widths; the top's PE_COUNT/DATA_WIDTH default to these and must
  // be overridden together with them.
  localparam int SIMD_LANES = 4;
  localparam int SIMD_DW    = 32;

  typedef struct packed {
    logic [SIMD_LANES-1:0][SIMD_DW-1:0] res;
    logic [SIMD_LANES-1:0]              mask;
    logic                               acc;
    logic                               acc_clr;
  } stage_t;

endpackage

// File: rtl/pe.sv
// Single-lane processing element: combinational two's-complement ALU,
// results wrap modulo 2^DATA_WIDTH.
module pe
  import simd_pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0]   a_i,
  input  logic signed [DATA_WIDTH-1:0]   b_i,
  input  logic        [OP_SEL_WIDTH-1:0] op_i,
  output logic signed [DATA_WIDTH-1:0]   c_o
);

  // Lane operation select; multiply keeps the low DATA_WIDTH bits.
  always_comb begin
    c_o = '0;
    case (op_i)
      OP_ADD:  c_o = a_i + b_i;
      OP_SUB:  c_o = a_i - b_i;
      OP_MUL:  c_o = a_i * b_i;
      default: c_o = a_i ^ b_i;
    endcase
  end

endmodule

// File: rtl/simd_pe_array_pipe_stage.sv
// One valid/ready register slice. Ready ripples combinationally from the
// downstream side so a full slice can accept while it drains.
module simd_pipe_stage
  import simd_pe_array_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   valid_i,
  output logic   ready_o,
  input  stage_t data_i,
  output logic   valid_o,
  input  logic   ready_i,
  output stage_t data_o
);

  logic   valid_q, valid_d;
  stage_t data_q, data_d;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Load on ready; payload only changes when a new op actually arrives.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  // Slice state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/simd_pe_array.sv
// Elastic SIMD PE array: PE_COUNT lanes of pe feeding PIPE_STAGES register
// slices, with per-lane masking. Define SIMD_PE_ACC_EN to add a per-lane
// accumulator applied at the last stage on the output handshake.
module simd_pe_array
  import simd_pe_array_pkg::*;
#(
  parameter int PE_COUNT    = SIMD_LANES,
  parameter int DATA_WIDTH  = SIMD_DW,
  parameter int PIPE_STAGES = 2
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] a,
  input  logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] b,
  input  logic        [OP_SEL_WIDTH-1:0]           pe_op,
  input  logic        [PE_COUNT-1:0]               lane_mask,
  input  logic                                     acc,
  input  logic                                     acc_clr,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [PE_COUNT-1:0][DATA_WIDTH-1:0] pe_out
);

  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] c;
  logic [PIPE_STAGES:0]                vld_pipe;
  logic [PIPE_STAGES:0]                rdy_pipe;
  stage_t                              pl [PIPE_STAGES+1];
  stage_t                              last;

  for (genvar i = 0; i < PE_COUNT; i++) begin : g_lane
    pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
      .a_i (a[i]),
      .b_i (b[i]),
      .op_i(pe_op),
      .c_o (c[i])
    );
  end

  // Stage 0 payload: lane results, mask and (when enabled) the acc flags.
  always_comb begin
    pl[0].res  = c;
    pl[0].mask = lane_mask;
`ifdef SIMD_PE_ACC_EN
    pl[0].acc     = acc;
    pl[0].acc_clr = acc_clr;
`else
    pl[0].acc     = 1'b0;
    pl[0].acc_clr = 1'b0;
`endif
  end

  assign vld_pipe[0]           = in_valid;
  assign in_ready              = rdy_pipe[0];
  assign rdy_pipe[PIPE_STAGES] = out_ready;
  assign out_valid             = vld_pipe[PIPE_STAGES];
  assign last                  = pl[PIPE_STAGES];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    simd_pipe_stage u_stage (
      .clk    (clk),
      .rstn   (rstn),
      .valid_i(vld_pipe[k]),
      .ready_o(rdy_pipe[k]),
      .data_i (pl[k]),
      .valid_o(vld_pipe[k+1]),
      .ready_i(rdy_pipe[k+1]),
      .data_o (pl[k+1])
    );
  end

`ifdef SIMD_PE_ACC_EN
  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] acc_q, acc_d, sum;

  // Output mux and accumulator next-state; acc_reg only moves on handshake
  // so back-to-back acc ops see the previous op's committed sum.
  always_comb begin
    acc_d  = acc_q;
    sum    = '0;
    pe_out = '0;
    for (int i = 0; i < PE_COUNT; i++) begin
      sum[i] = (last.acc_clr ? '0 : acc_q[i]) + last.res[i];
      if (last.mask[i]) pe_out[i] = last.acc ? sum[i] : last.res[i];
      if (out_valid && out_ready && last.acc && last.mask[i]) acc_d[i] = sum[i];
    end
  end

  // Per-lane accumulators, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`else
  logic unused_acc;
  assign unused_acc = ^{acc, acc_clr, last.acc, last.acc_clr};

  // Output mux: masked lanes read as zero.
  always_comb begin
    pe_out = '0;
    for (int i = 0; i < PE_COUNT; i++)
      if (last.mask[i]) pe_out[i] = last.res[i];
  end
`endif

endmodule
